// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory port arbiter.
// Purely declarative: no latency and no backpressure of its own.
// State and requester IDs are fixed numeric values so waveforms decode consistently.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REQ_IF = 2'd0,
    REQ_DM = 2'd1,
    REQ_UB = 2'd2
  } req_id_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Fixed-priority picker UB > DM > IF; the UB bit arrives already masked by the top.
// Latency: purely combinational.
// Backpressure: none here; the caller only samples the result while idle.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    if_req_i,
  input  logic    dm_req_i,
  input  logic    ub_req_i,
  output logic    vld_o,
  output req_id_e id_o
);

  always_comb begin
    vld_o = if_req_i | dm_req_i | ub_req_i;
    id_o  = REQ_IF;
    if (ub_req_i) begin
      id_o = REQ_UB;
    end else if (dm_req_i) begin
      id_o = REQ_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetch, MEM lw/sw and UART boot writes onto one req/ack memory port.
// Latency: grant edge, then variable memory wait, then a one-cycle ready pulse (3 cycles zero-wait).
// Backpressure: requesters stall until their ready; optional UB port via MEM_ARB_UART_BOOT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,

  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,

  input  logic              ub_req,
  input  logic [ADDR_W-1:0] ub_addr,
  input  logic [DATA_W-1:0] ub_wdata,
  output logic              ub_ready,
  output logic              boot_active,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

`ifdef MEM_ARB_UART_BOOT_EN
  localparam logic UB_EN = 1'b1;
`else
  localparam logic UB_EN = 1'b0;
`endif

  state_e            state_q;
  req_id_e           win_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_ready_q;
  logic              dm_ready_q;
  logic              ub_ready_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic              ub_req_m;
  logic              dm_req;
  logic              pick_vld;
  req_id_e           pick_id;
  logic              win_we_d;
  logic [ADDR_W-1:0] win_addr_d;
  logic [DATA_W-1:0] win_wdata_d;

  assign ub_req_m = ub_req & UB_EN;
  assign dm_req   = dm_read | dm_write;

  mem_arb_pick u_pick (
    .if_req_i (if_req),
    .dm_req_i (dm_req),
    .ub_req_i (ub_req_m),
    .vld_o    (pick_vld),
    .id_o     (pick_id)
  );

  // A DM access with both strobes high is treated as a store.
  always_comb begin
    win_we_d    = 1'b0;
    win_addr_d  = if_addr;
    win_wdata_d = '0;
    case (pick_id)
      REQ_UB: begin
        win_we_d    = 1'b1;
        win_addr_d  = ub_addr;
        win_wdata_d = ub_wdata;
      end
      REQ_DM: begin
        win_we_d    = dm_write;
        win_addr_d  = dm_addr;
        win_wdata_d = dm_wdata;
      end
      default: begin
        win_we_d    = 1'b0;
        win_addr_d  = if_addr;
        win_wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      win_q       <= REQ_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      ub_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            state_q     <= ST_BUSY;
            win_q       <= pick_id;
            mem_req_q   <= 1'b1;
            mem_we_q    <= win_we_d;
            mem_addr_q  <= win_addr_d;
            mem_wdata_q <= win_wdata_d;
          end
        end
        ST_BUSY: begin
          if (mem_ack) begin
            state_q   <= ST_DONE;
            mem_req_q <= 1'b0;
            case (win_q)
              REQ_UB: ub_ready_q <= 1'b1;
              REQ_DM: begin
                dm_ready_q <= 1'b1;
                if (!mem_we_q) begin
                  dm_rdata_q <= mem_rdata;
                end
              end
              default: begin
                if_ready_q <= 1'b1;
                if_rdata_q <= mem_rdata;
              end
            endcase
          end
        end
        ST_DONE: begin
          // Acks landing here are stale and deliberately dropped.
          state_q    <= ST_IDLE;
          if_ready_q <= 1'b0;
          dm_ready_q <= 1'b0;
          ub_ready_q <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          mem_req_q  <= 1'b0;
          if_ready_q <= 1'b0;
          dm_ready_q <= 1'b0;
          ub_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_ready    = if_ready_q;
  assign dm_ready    = dm_ready_q;
  assign ub_ready    = ub_ready_q & UB_EN;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign boot_active = ub_req_m;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; expectations follow MEM_ARB_UART_BOOT_EN when defined.
// Drives and samples on the falling clock edge.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

`ifdef MEM_ARB_UART_BOOT_EN
  localparam logic UB_ON = 1'b1;
`else
  localparam logic UB_ON = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_read, dm_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              ub_req;
  logic [ADDR_W-1:0] ub_addr;
  logic [DATA_W-1:0] ub_wdata;
  logic              ub_ready;
  logic              boot_active;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .ub_req(ub_req), .ub_addr(ub_addr), .ub_wdata(ub_wdata), .ub_ready(ub_ready),
    .boot_active(boot_active),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              ub_req;
    logic [ADDR_W-1:0] ub_addr;
    logic [DATA_W-1:0] ub_wdata;
    int                delay;
    logic [DATA_W-1:0] rdata;
    logic [2:0]        exp_rdy;   // {ub, dm, if}
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;
    logic [DATA_W-1:0] exp_if_rdata;
    logic [DATA_W-1:0] exp_dm_rdata;
    logic              exp_boot;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drop_all();
    if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0; ub_req = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    @(negedge clock);
    if_req = v.if_req;   if_addr = v.if_addr;
    dm_read = v.dm_read; dm_write = v.dm_write; dm_addr = v.dm_addr; dm_wdata = v.dm_wdata;
    ub_req = v.ub_req;   ub_addr = v.ub_addr;   ub_wdata = v.ub_wdata;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (mem_req !== 1'b1 && n < 8);
    chk({tag, "_grant"}, 64'(mem_req), 64'(1'b1));
    chk({tag, "_boot"}, 64'(boot_active), 64'(v.exp_boot));
    chk({tag, "_we"}, 64'(mem_we), 64'(v.exp_we));
    chk({tag, "_addr"}, 64'(mem_addr), 64'(v.exp_addr));
    if (v.exp_we) chk({tag, "_wdata"}, 64'(mem_wdata), 64'(v.exp_wdata));
    repeat (v.delay) @(negedge clock);
    chk({tag, "_wait"}, 64'({mem_req, ub_ready, dm_ready, if_ready}), 64'(4'b1000));
    mem_ack = 1'b1; mem_rdata = v.rdata;
    @(negedge clock);
    mem_ack = 1'b0; mem_rdata = '0;
    chk({tag, "_ready"}, 64'({ub_ready, dm_ready, if_ready}), 64'(v.exp_rdy));
    chk({tag, "_reqlow"}, 64'(mem_req), 64'(1'b0));
    chk({tag, "_if_rdata"}, 64'(if_rdata), 64'(v.exp_if_rdata));
    chk({tag, "_dm_rdata"}, 64'(dm_rdata), 64'(v.exp_dm_rdata));
    drop_all();
    @(negedge clock);
    chk({tag, "_pulse1"}, 64'({ub_ready, dm_ready, if_ready}), 64'(3'b000));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dm_cyc, if_cyc;
    logic got_first, first_we;
    logic [ADDR_W-1:0] first_addr;
    logic [DATA_W-1:0] first_wdata;

    //            if  if_addr       rd    wr    dm_addr     dm_wdata       ub    ub_addr    ub_wdata       dly rdata          rdy     we    exp_addr      exp_wdata      if_rdata       dm_rdata       boot
    vecs[0] = '{1'b1, 30'h10,       1'b0, 1'b0, 30'h0,  32'h0,         1'b0, 30'h0, 32'h0,         2, 32'h8C010004, 3'b001, 1'b0, 30'h10,       32'h0,         32'h8C010004, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 30'h0,        1'b1, 1'b0, 30'h20, 32'h0,         1'b0, 30'h0, 32'h0,         0, 32'h11112222, 3'b010, 1'b0, 30'h20,       32'h0,         32'h8C010004, 32'h11112222, 1'b0};
    vecs[2] = '{1'b0, 30'h0,        1'b0, 1'b1, 30'h40, 32'hDEADBEEF,  1'b0, 30'h0, 32'h0,         1, 32'hBADBAD00, 3'b010, 1'b1, 30'h40,       32'hDEADBEEF,  32'h8C010004, 32'h11112222, 1'b0};
    vecs[3] = '{1'b0, 30'h0,        1'b1, 1'b1, 30'h44, 32'hCAFEF00D,  1'b0, 30'h0, 32'h0,         0, 32'h99999999, 3'b010, 1'b1, 30'h44,       32'hCAFEF00D,  32'h8C010004, 32'h11112222, 1'b0};
    vecs[4] = '{1'b1, 30'h8,        1'b1, 1'b0, 30'h30, 32'h0,         1'b0, 30'h0, 32'h0,         1, 32'h12345678, 3'b010, 1'b0, 30'h30,       32'h0,         32'h8C010004, 32'h12345678, 1'b0};
`ifdef MEM_ARB_UART_BOOT_EN
    vecs[5] = '{1'b1, 30'h4,        1'b0, 1'b0, 30'h0,  32'h0,         1'b1, 30'h0, 32'h20080005,  0, 32'h00000077, 3'b100, 1'b1, 30'h0,        32'h20080005,  32'h8C010004, 32'h12345678, 1'b1};
    vecs[6] = '{1'b1, 30'h3FFFFFFF, 1'b0, 1'b0, 30'h0,  32'h0,         0,    30'h0, 32'h0,         3, 32'hFFFFFFFF, 3'b001, 1'b0, 30'h3FFFFFFF, 32'h0,         32'hFFFFFFFF, 32'h12345678, 1'b0};
`else
    vecs[5] = '{1'b1, 30'h4,        1'b0, 1'b0, 30'h0,  32'h0,         1'b1, 30'h0, 32'h20080005,  0, 32'h00000077, 3'b001, 1'b0, 30'h4,        32'h0,         32'h00000077, 32'h12345678, 1'b0};
    vecs[6] = '{1'b1, 30'h3FFFFFFF, 1'b0, 1'b0, 30'h0,  32'h0,         0,    30'h0, 32'h0,         3, 32'hFFFFFFFF, 3'b001, 1'b0, 30'h3FFFFFFF, 32'h0,         32'hFFFFFFFF, 32'h12345678, 1'b0};
`endif

    reset_n = 1'b0;
    drop_all();
    if_addr = '0; dm_addr = '0; dm_wdata = '0; ub_addr = '0; ub_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    chk("reset_outputs", 64'({mem_req, mem_we, if_ready, dm_ready, ub_ready, boot_active}), 64'(6'b0));
    chk("reset_rdata", 64'(if_rdata | dm_rdata), 64'(0));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_after_reset", 64'({mem_req, mem_addr}), 64'(0));

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous IF read and DM write, both held until served, zero-wait memory.
    @(negedge clock);
    if_req = 1'b1; if_addr = 30'h18;
    dm_write = 1'b1; dm_addr = 30'h40; dm_wdata = 32'hDEADBEEF;
    mem_rdata = 32'h0BADF00D;
    dm_cyc = -1; if_cyc = -1; got_first = 1'b0;
    first_we = 1'b0; first_addr = '0; first_wdata = '0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clock);
      mem_ack = mem_req;
      if (mem_req && !got_first) begin
        got_first = 1'b1; first_we = mem_we; first_addr = mem_addr; first_wdata = mem_wdata;
      end
      if (dm_ready) begin dm_cyc = cyc; dm_write = 1'b0; end
      if (if_ready) begin if_cyc = cyc; if_req = 1'b0; end
      if (dm_cyc > 0 && if_cyc > 0) break;
    end
    mem_ack = 1'b0; mem_rdata = '0;
    chk("simul_first_we", 64'(first_we), 64'(1'b1));
    chk("simul_first_addr", 64'(first_addr), 64'(30'h40));
    chk("simul_first_wdata", 64'(first_wdata), 64'(32'hDEADBEEF));
    chk("simul_dm_cycle", 64'(dm_cyc), 64'(2));
    chk("simul_if_cycle", 64'(if_cyc), 64'(5));
    chk("simul_if_rdata", 64'(if_rdata), 64'(32'h0BADF00D));
    chk("simul_dm_rdata", 64'(dm_rdata), 64'(32'h12345678));

    // Spurious ack while idle.
    repeat (2) @(negedge clock);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    repeat (2) @(negedge clock);
    chk("spur_state", 64'({mem_req, ub_ready, dm_ready, if_ready}), 64'(4'b0));
    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clock);
    chk("spur_no_pulse", 64'({ub_ready, dm_ready, if_ready}), 64'(3'b0));
    chk("spur_rdata", 64'(if_rdata), 64'(32'h0BADF00D));

    // Reset during BUSY, then a late ack after release.
    if_req = 1'b1; if_addr = 30'h50;
    @(negedge clock);
    chk("rst_busy_req", 64'(mem_req), 64'(1'b1));
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_req", 64'({mem_req, mem_we, mem_addr}), 64'(0));
    chk("rst_async_rdy", 64'({ub_ready, dm_ready, if_ready}), 64'(3'b0));
    chk("rst_async_rdata", 64'(if_rdata | dm_rdata), 64'(0));
    if_req = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    @(negedge clock);
    mem_ack = 1'b0; mem_rdata = '0;
    chk("rst_late_ack", 64'({mem_req, ub_ready, dm_ready, if_ready}), 64'(4'b0));
    @(negedge clock);
    chk("rst_late_ack2", 64'({ub_ready, dm_ready, if_ready}), 64'(3'b0));
    chk("rst_late_rdata", 64'(if_rdata), 64'(0));

    // Request dropped after grant still completes with a ready pulse.
    if_req = 1'b1; if_addr = 30'h7;
    @(negedge clock);
    if_req = 1'b0;
    chk("early_grant", 64'({mem_req, mem_addr}), 64'({1'b1, 30'h7}));
    mem_ack = 1'b1; mem_rdata = 32'h13579BDF;
    @(negedge clock);
    mem_ack = 1'b0; mem_rdata = '0;
    chk("early_ready", 64'(if_ready), 64'(1'b1));
    chk("early_rdata", 64'(if_rdata), 64'(32'h13579BDF));
    @(negedge clock);
    chk("early_idle", 64'({mem_req, if_ready}), 64'(2'b00));

    // Boot request alone: boot_active and ub_ready depend on the build option.
    ub_req = 1'b1; ub_addr = 30'h100; ub_wdata = 32'h0000CAFE;
    #1;
    chk("ub_boot_active", 64'(boot_active), 64'(UB_ON));
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clock);
      mem_ack = mem_req;
    end
    mem_ack = 1'b0;
    chk("ub_only_served", 64'({mem_req, mem_addr == 30'h100}), 64'({1'b0, UB_ON}));
    ub_req = 1'b0;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified instruction/data memory between three requesters: the IF stage's instruction fetch, the MEM stage's lw/sw, and the UART bootloader that writes program images. It is a small FSM with fixed priority. It latches the winning request, drives a req/ack memory port with variable latency, and returns a one-cycle `ready` pulse with read data to the winner. The pipeline stalls each requester while its `ready` is low.

## Interface
- `ADDR_W`, 30: word address width.
- `DATA_W`, 32: data width.

- `clock`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request (level, held until `if_ready`).
- `if_addr`  in  ADDR_W  fetch word address.
- `if_rdata`  out  DATA_W  fetched instruction, valid with `if_ready`.
- `if_ready`  out  1  one-cycle completion pulse.
- `dm_read`, `dm_write`  in  1  data read / write request (level).
- `dm_addr`  in  ADDR_W; `dm_wdata`  in  DATA_W.
- `dm_rdata`  out  DATA_W; `dm_ready`  out  1  completion pulse.
- `ub_req`  in  1  bootloader write request; `ub_addr`  in  ADDR_W; `ub_wdata`  in  DATA_W.
- `ub_ready`  out  1  completion pulse.
- `boot_active`  out  1  high while `ub_req` is high; holds the core's PC/pipeline.
- `mem_req`, `mem_we`  out  1; `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W.
- `mem_rdata`  in  DATA_W; `mem_ack`  in  1  memory completion (one cycle).

## Operation
- The FSM has three states: IDLE, BUSY, DONE. It resets to IDLE.
- **IDLE:** the block picks a winner with fixed priority UB > DM > IF. It latches the winner ID, address, write data and write enable, then moves to BUSY. If there are no requests, it stays in IDLE.
- **DM requests:** if `dm_write` is high the access is a write, even when `dm_read` is also high. UB accesses are always writes. IF accesses are always reads.
- **BUSY:** `mem_req`=1 and the latched address, data and write enable are driven. When `mem_ack`=1 the block captures `mem_rdata` into the winner's rdata register (reads only) and moves to DONE.
- **DONE:** the winner's `ready` is 1 for exactly this cycle, then the FSM returns to IDLE unconditionally.
- **Requester obligations:** requesters hold request, address and data stable until their `ready`. A request dropped early does not abort the access; the transaction completes and `ready` still pulses.
- **Spurious ack:** `mem_ack` in IDLE or DONE is ignored.
- **Read data hold:** `if_rdata` and `dm_rdata` hold their last captured value until the next read completes for the same requester.
- **Reset:** reset asserted mid-transaction forces IDLE asynchronously. All outputs go to 0, and an ack arriving after reset is ignored.
- **Reset values:** all outputs and registers are 0.

## Timing
- Request sampled at edge E0 (IDLE → BUSY) → `mem_req` high from E0.
- Ack sampled at edge Ek (k ≥ 1) → `mem_req` low and `ready` high from Ek → IDLE at Ek+1.
- Zero-wait memory: 3 cycles per access and at most one access in flight.
- A requester still asserting after DONE is re-arbitrated at the next IDLE edge.
- There is no combinational path from request inputs to `mem_*`. `boot_active` is the only combinational output (`ub_req`, gated by the macro).

## Configuration
- `MEM_ARB_UART_BOOT_EN` defined: the UB requester participates in arbitration and `boot_active` follows `ub_req`.
- Not defined:
  - UB inputs are ignored.
  - `ub_ready` and `boot_active` are tied to 0.
  - Arbitration is DM > IF only.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state encoding (IDLE=0, BUSY=1, DONE=2);
  - the requester IDs (REQ_IF=0, REQ_DM=1, REQ_UB=2).
- Sub-module `mem_arb_pick` is a purely combinational priority picker. It takes the three request bits (UB bit masked by the macro) and returns a valid bit plus the winner ID.
- The top level holds the FSM, the latches and the per-requester rdata registers.

## Test plan
- **IF read, 2-cycle ack:** `if_req`=1, `if_addr`=0x10; memory acks 2 cycles after `mem_req` with 0x8C010004 → `mem_addr`=0x10, `mem_we`=0; one-cycle `if_ready` with `if_rdata`=0x8C010004.
- **Simultaneous IF and DM write:** `if_req`=1 and `dm_write`=1 (addr 0x40, data 0xDEADBEEF) together, zero-wait ack → DM write served first, then IF read. `dm_ready` and `if_ready` pulse 3 cycles apart.
- **Boot write, macro defined:** `ub_req`=1 (addr 0x0, data 0x20080005) while `if_req`=1 → `boot_active`=1, UB write issued first, `ub_ready` pulses. Macro undefined → only IF is served and `ub_ready` never asserts.
- **Both DM bits high:** `dm_read`=`dm_write`=1 → `mem_we`=1 and `dm_rdata` is unchanged.
- **Reset mid-transaction:** `reset_n` low during BUSY → `mem_req`=0 immediately and all `ready`=0. A late `mem_ack` after release produces no `ready` pulse.
- **Spurious ack:** `mem_ack`=1 in IDLE → no state change, no `ready`.
